rr_slot_arbiter: RTL
====================

Name: rr_slot_arbiter

Overview:
Four-requester round-robin arbiter that shares one resource among requesters 0-3 (for example, the scanned display/operand slots of the calculator). It keeps a one-hot rotating priority pointer and issues one registered one-hot grant at a time. Each grant is held until the owner releases it, and a dead cycle separates consecutive grants. A controller module drives this block and sequences it with the other blocks of the calculator datapath.

Parameters:
MAX_HOLD, 16, maximum cycles a grant may be held (used only with HOLD_TIMEOUT_EN); legal range 2..255
CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
req  input  4  request lines; bit i belongs to requester i
release  input  1  current owner finished; sampled only in GRANT
grant  output  4  one-hot grant, registered; 4'b0000 when nothing is granted
grant_id  output  2  binary index of the granted requester; holds the last value when idle
busy  output  1  high while grant is non-zero
timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit; constant 0 without the macro

Behaviour:
- Clock and reset: clock clk. Reset reset is synchronous and active-high; it has priority over all other logic.
- Reset values: state=IDLE, ptr=4'b0001, grant=4'b0000, grant_id=2'd0, busy=0, timeout=0, hold counter=0.
- State machine: IDLE -> GRANT -> GAP -> IDLE.
- IDLE, req==0: stay in IDLE; all outputs stay at their idle values.
- IDLE, req!=0: the winner is the first set req bit found starting at ptr, searching upward and wrapping 3->0.
  - At the next edge: grant=onehot(winner), grant_id=winner, busy=1, state=GRANT.
  - Latency: req sampled at edge N gives grant valid after edge N.
- GRANT, hold: stay in GRANT while req[grant_id]=1 and release=0.
- GRANT, end of grant: a grant ends when release=1, or when req[grant_id] drops, or when both happen in the same cycle. At the next edge:
  - grant=0 and busy=0;
  - ptr = onehot(grant_id) rotated left by one (bit3 wraps to bit0);
  - state=GAP.
- GAP: lasts exactly one cycle; requests are ignored; state then returns to IDLE.
  - A continuously requesting population therefore sees grant low for 2 cycles (GAP, then IDLE evaluation) between grants.
- Changes on non-owner req lines during GRANT have no effect.
- release outside GRANT is ignored.
- Fairness: with all four requesting continuously, grant order is 0,1,2,3,0,…; no requester waits more than 3 grants.
- Invariants: grant is always zero or one-hot; ptr is always one-hot.
- Reset mid-GRANT: the grant drops at that edge and ptr returns to 4'b0001.

Optional Feature:
HOLD_TIMEOUT_EN
- Defined:
  - The hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When the counter reaches MAX_HOLD-1 and no release is present, the grant is revoked at the next edge, exactly as for a release (ptr advances, state=GAP).
  - timeout=1 for that single GAP cycle.
  - A release in the same cycle as the limit counts as a normal release, with timeout=0.
- Not defined: the counter logic is absent, timeout is tied to 0, and a grant can be held indefinitely.

Test Plan:
1. Reset, then req=4'b0100 held and release pulsed on the 3rd GRANT cycle -> grant=4'b0100 and grant_id=2 one cycle after req; grant=0 after release; next winner searches from ptr=4'b1000.
2. req=4'b1111 continuous, release pulsed every 2nd GRANT cycle -> grant sequence 0001,0010,0100,1000,0001 with exactly 2 zero cycles between grants.
3. Owner 1 granted, req[1] drops with release=0 -> grant=0 next edge; req=4'b0011 then grants requester 0 (ptr=4'b0100, wrap search 2,3,0).
4. Reset asserted during GRANT of requester 3 -> grant=0, busy=0, grant_id=0 next edge; with req=4'b1001 afterwards, requester 0 wins.
5. HOLD_TIMEOUT_EN with MAX_HOLD=4, req[2] held and no release -> grant held 4 cycles, then grant=0 with timeout=1 for one cycle, and requester 3 is granted next if it is requesting.
6. Release pulsed in IDLE with req=0 -> no state change; grant stays 0 and ptr is unchanged.

Source files
------------

// File: rtl/rr_slot_arbiter.sv
// Four-requester round-robin slot arbiter: registered one-hot grant, one GAP cycle between grants.
// Optional hold-time limit enabled by defining HOLD_TIMEOUT_EN.
module rr_slot_arbiter #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  // The owner's release strobe; "release" itself is a reserved word.
  input  logic       release_grant,
  output logic [3:0] grant,
  output logic [1:0] grant_id,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

  state_e     state_q, state_d;
  logic [3:0] ptr_q, ptr_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] id_q, id_d;
  logic [1:0] ptr_idx;
  logic [1:0] winner;
  logic       revoke;

  always_comb begin
    ptr_idx = 2'd0;
    unique case (ptr_q)
      4'b0001: ptr_idx = 2'd0;
      4'b0010: ptr_idx = 2'd1;
      4'b0100: ptr_idx = 2'd2;
      4'b1000: ptr_idx = 2'd3;
      default: ptr_idx = 2'd0;
    endcase
  end

  // Scan from the farthest offset down so the nearest set bit after ptr wins.
  always_comb begin
    winner = ptr_idx;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr_idx + 2'(k)]) winner = ptr_idx + 2'(k);
    end
  end

`ifdef HOLD_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             timeout_q, timeout_d;

  assign revoke     = hold_cnt_q == CNT_W'(MAX_HOLD - 1);
  assign hold_cnt_d = (state_q == StGrant) ? hold_cnt_q + 1'b1 : '0;
  assign timeout_d  = (state_q == StGrant) && revoke && !release_grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_params;
  assign unused_params = ^{32'(MAX_HOLD), 32'(CNT_W)};
  assign revoke        = 1'b0;
  assign timeout       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    id_d    = id_q;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          grant_d = 4'b0001 << winner;
          id_d    = winner;
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (release_grant || !req[id_q] || revoke) begin
          grant_d = 4'b0000;
          ptr_d   = {grant_q[2:0], grant_q[3]};
          state_d = StGap;
        end
      end
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= 4'b0001;
      grant_q <= 4'b0000;
      id_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      id_q    <= id_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = id_q;
  assign busy     = |grant_q;

endmodule
